seq_mult4: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/rca.sv | 21 ++
 rtl/seq_mult4.sv | 111 +++++++++++
 tb/tb_seq_mult4.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the sequential 4x4 shift-add multiplier.
package seq_mult_pkg;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 2;
    localparam int PROD_W = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CALC = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC
    } state_e;

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry adder used as the add stage of the multiplier.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] sum,
    output logic       carry
);

    logic [4:0] chain;

    assign chain[0] = c;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ chain[gi];
        assign chain[gi+1] = (a[gi] & b[gi]) | (chain[gi] & (a[gi] ^ b[gi]));
    end

    assign carry = chain[4];

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-add multiplier: one product every 4 compute cycles,
// with a start/busy/done handshake and the rca as its only adder.
module seq_mult4 #(
    parameter int WIDTH = seq_mult_pkg::WIDTH,
    parameter int CNT_W = seq_mult_pkg::CNT_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic                            busy,
    output logic                            done,
    output logic [seq_mult_pkg::PROD_W-1:0] product
);

    import seq_mult_pkg::*;

    if (WIDTH != 4) begin : g_bad_width
        $error("seq_mult4: WIDTH must be 4 (rca stage is 4 bits wide)");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PROD_W-1:0]  product_q, product_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;
    logic [PROD_W-1:0]  shifted;

    assign add_b = lo_q[0] ? mcand_q : '0;

    rca u_rca (
        .a     (hi_q),
        .b     (add_b),
        .c     (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Adder carry lands in the top bit so no product bit is ever lost.
    assign shifted = {add_carry, add_sum, lo_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                {hi_d, lo_d} = shifted;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = shifted;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult4.sv
// Directed self-checking bench for seq_mult4; inputs change and outputs are sampled on falling edges.
module tb_seq_mult4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int errors = 0;
    int checks = 0;

    seq_mult4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start pulse in cycle 1, then watch cycles 2..9 for exactly one done with the expected product.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp, input string tag);
        int pulses;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                pulses++;
                chk({tag, " product"}, product, exp);
            end
            @(negedge clk);
        end
        chk({tag, " pulses"}, 8'(pulses), 8'd1);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;

        // Reset held: random requests must not disturb the idle outputs.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'($urandom);
            a     = 4'($urandom);
            b     = 4'($urandom);
            chk("rst busy", 8'(busy), 8'd0);
            chk("rst done", 8'(done), 8'd0);
            chk("rst product", product, 8'h00);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle busy", 8'(busy), 8'd0);
            chk("idle done", 8'(done), 8'd0);
        end

        // F*F latency: busy cycles 2-5, done in 6, product held afterwards.
        @(negedge clk);
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 2; cyc <= 5; cyc++) begin
            chk($sformatf("lat busy c%0d", cyc), 8'(busy), 8'd1);
            chk($sformatf("lat done c%0d", cyc), 8'(done), 8'd0);
            @(negedge clk);
        end
        chk("lat busy c6", 8'(busy), 8'd0);
        chk("lat done c6", 8'(done), 8'd1);
        chk("lat product c6", product, 8'hE1);
        @(negedge clk);
        chk("lat done c7", 8'(done), 8'd0);
        chk("lat product c7", product, 8'hE1);

        run_op(4'h0, 4'hF, 8'h00, "0*F");
        run_op(4'hF, 4'h1, 8'h0F, "F*1");
        run_op(4'hA, 4'h3, 8'h1E, "A*3");
        run_op(4'h1, 4'h8, 8'h08, "1*8");

        // Start during CALC is ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 4'h3;
        b     = 4'h5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                pulses++;
                chk("ign product", product, 8'h0F);
            end
            @(negedge clk);
        end
        chk("ign pulses", 8'(pulses), 8'd1);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        a     = 4'h2;
        b     = 4'h3;
        for (int cyc = 2; cyc <= 5; cyc++) begin
            @(negedge clk);
        end
        @(negedge clk);
        chk("b2b done c6", 8'(done), 8'd1);
        chk("b2b product c6", product, 8'h06);
        a = 4'h7;
        b = 4'h9;
        for (int cyc = 7; cyc <= 10; cyc++) begin
            @(negedge clk);
            chk($sformatf("b2b hold c%0d", cyc), product, 8'h06);
            chk($sformatf("b2b busy c%0d", cyc), 8'(busy), 8'd1);
            chk($sformatf("b2b done c%0d", cyc), 8'(done), 8'd0);
        end
        @(negedge clk);
        chk("b2b done c11", 8'(done), 8'd1);
        chk("b2b product c11", product, 8'h3F);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset pulse during cycle 4 of a 6*7 run.
        @(negedge clk);
        start = 1'b1;
        a     = 4'h6;
        b     = 4'h7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort busy", 8'(busy), 8'd0);
        chk("abort product", product, 8'h00);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort pulses", 8'(pulses), 8'd0);
        chk("abort product held", product, 8'h00);
        run_op(4'h5, 4'h5, 8'h19, "5*5");

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 8'(i * j), $sformatf("mul %0d*%0d", i, j));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
